adc_frontend: RTL

ADC_FRONTEND -- requirements
Module: adc_frontend

---
 rtl/adc_pkg.sv | 24 ++
 rtl/adc_decimator.sv | 94 +++++++++
 rtl/adc_frontend.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC front end: default widths, the result
// routing action used by the output register, and the accumulator-to-output
// scaling helper.
package adc_pkg;

    localparam int ADC_W_DEF  = 14;
    localparam int OUT_W_DEF  = 16;
    localparam int DROP_CNT_W = 16;

    // What the output register does with a freshly produced result.
    typedef enum logic [1:0] {
        RES_NONE,   // no result this cycle
        RES_LOAD,   // output slot free or being accepted: take the result
        RES_DROP    // output slot held by a stalled consumer: discard
    } res_action_e;

    // Shift between the accumulator (sum_w bits) and the output word.
    // Positive: shift left by that many bits; negative: arithmetic shift
    // right by its magnitude, dropping the low bits.
    function automatic int scale_shift(input int out_w, input int sum_w);
        return out_w - sum_w;
    endfunction

endpackage

// File: rtl/adc_decimator.sv
// Boxcar decimator: sums 2^DECIM_LOG2 offset-corrected samples, then emits
// one scaled result and starts a fresh group. Only valid input samples
// advance the group, so gaps in the sample stream are harmless.
module adc_decimator
    import adc_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int DECIM_LOG2 = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    input  logic signed [ADC_W:0]   in_diff_i,
    output logic                    res_valid_o,
    output logic signed [OUT_W-1:0] res_data_o
);

    localparam int SW    = ADC_W + 1 + DECIM_LOG2;
    localparam int SHIFT = scale_shift(OUT_W, SW);
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    logic signed [SW-1:0]    sum_q, sum_d;
    logic signed [SW-1:0]    diff_ext;
    logic signed [SW-1:0]    sum_next;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    res_valid_q, res_valid_d;
    logic signed [OUT_W-1:0] res_data_q, res_data_d;
    logic signed [OUT_W-1:0] scaled;

    // Sign-extend the incoming difference to the accumulator width.
    if (DECIM_LOG2 == 0) begin : g_ext_none
        assign diff_ext = in_diff_i;
    end else begin : g_ext_sign
        assign diff_ext = {{DECIM_LOG2{in_diff_i[ADC_W]}}, in_diff_i};
    end

    assign sum_next = sum_q + diff_ext;

    // Map the completed group sum onto the output word.
    if (SHIFT >= 0) begin : g_scale_up
        assign scaled = OUT_W'(sum_next) << SHIFT;
    end else begin : g_scale_down
        assign scaled = OUT_W'(sum_next >>> (-SHIFT));
    end

    // Next-state for the running sum, group counter and result strobe.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        if (in_valid_i) begin
            if (cnt_q == CNT_LAST) begin
                sum_d       = '0;
                cnt_d       = '0;
                res_valid_d = 1'b1;
                res_data_d  = scaled;
            end else begin
                sum_d = sum_next;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Control state with synchronous reset: a partial group is discarded.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples values
        // from before this edge regardless of statement order.
        if (!rst_n) begin
            sum_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Result payload, only meaningful while res_valid_q is set.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are deliberately left out of reset; their
        // qualifying valid bit is reset, which is all correctness needs.
        res_data_q <= res_data_d;
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;

endmodule

// File: rtl/adc_frontend.sv
// ADC front end: captures raw ADC codes, normalises format and bit order,
// subtracts a DC offset, decimates, and presents results through a
// valid/ready output register that counts results lost to back-pressure.
// A stretched overrange flag reports clipped input codes.
module adc_frontend
    import adc_pkg::*;
#(
    parameter int ADC_W         = ADC_W_DEF,
    parameter int OUT_W         = OUT_W_DEF,
    parameter int DECIM_LOG2    = 0,
    parameter int OFFSET_BINARY = 0,
    parameter int BIT_REVERSE   = 0,
    parameter int OVR_HOLD      = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADC_W-1:0]        adc_data,
    input  logic                    adc_en,
    input  logic signed [ADC_W-1:0] cfg_offset,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    ovr,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam logic [ADC_W-1:0] MSB_ONLY = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [ADC_W-1:0] CODE_MIN = (OFFSET_BINARY != 0) ? '0 : MSB_ONLY;
    localparam logic [ADC_W-1:0] CODE_MAX = (OFFSET_BINARY != 0) ? '1 : ~MSB_ONLY;
    localparam int               HOLD_W   = (OVR_HOLD > 0) ? $clog2(OVR_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVR_HOLD);

    // ---------------- stage 1: pin capture ----------------
    logic [ADC_W-1:0] pins_ord;
    logic             s1_valid_q;
    logic [ADC_W-1:0] s1_code_q;

    if (BIT_REVERSE != 0) begin : g_rev
        for (genvar i = 0; i < ADC_W; i++) begin : g_bit
            assign pins_ord[i] = adc_data[ADC_W-1-i];
        end
    end else begin : g_norev
        assign pins_ord = adc_data;
    end

    // Stage-1 valid flag: set only on strobed edges.
    always_ff @(posedge clk) begin
        if (!rst_n) s1_valid_q <= 1'b0;
        else        s1_valid_q <= adc_en;
    end

    // Stage-1 code, captured on strobed edges.
    always_ff @(posedge clk) begin
        if (adc_en) s1_code_q <= pins_ord;
    end

    // ---------------- stage 2: format and offset ----------------
    logic signed [ADC_W-1:0] s1_sample;
    logic signed [ADC_W:0]   diff;
    logic                    s2_valid_q;
    logic signed [ADC_W:0]   s2_diff_q;

    // Offset-binary becomes two's complement by flipping the MSB. One extra
    // bit of headroom makes sample - offset exact for every input pair.
    assign s1_sample = (OFFSET_BINARY != 0) ? (s1_code_q ^ MSB_ONLY) : s1_code_q;
    assign diff      = {s1_sample[ADC_W-1], s1_sample} - {cfg_offset[ADC_W-1], cfg_offset};

    // Stage-2 valid flag follows stage 1 by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) s2_valid_q <= 1'b0;
        else        s2_valid_q <= s1_valid_q;
    end

    // Stage-2 difference, using the offset present on this very edge.
    always_ff @(posedge clk) begin
        if (s1_valid_q) s2_diff_q <= diff;
    end

    // ---------------- stage 3: decimation ----------------
    logic                    res_valid;
    logic signed [OUT_W-1:0] res_data;

    adc_decimator #(
        .ADC_W      (ADC_W),
        .OUT_W      (OUT_W),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_decimator (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s2_valid_q),
        .in_diff_i   (s2_diff_q),
        .res_valid_o (res_valid),
        .res_data_o  (res_data)
    );

    // ---------------- output register ----------------
    res_action_e             action;
    logic                    o_valid_q, o_valid_d;
    logic signed [OUT_W-1:0] o_data_q, o_data_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    // Route each new result (load or drop) and retire accepted data.
    always_comb begin
        action     = RES_NONE;
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        drop_cnt_d = drop_cnt_q;
        if (res_valid) begin
            action = (!o_valid_q || o_ready) ? RES_LOAD : RES_DROP;
        end
        case (action)
            RES_LOAD: begin
                o_valid_d = 1'b1;
                o_data_d  = res_data;
            end
            RES_DROP: begin
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
            default: begin
                if (o_valid_q && o_ready) o_valid_d = 1'b0;
            end
        endcase
    end

    // Output register and drop counter; reset wins over any load or accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ---------------- overrange stretch ----------------
    logic              ovr_hit;
    logic [HOLD_W-1:0] hold_q, hold_d;

    assign ovr_hit = s1_valid_q && ((s1_code_q == CODE_MIN) || (s1_code_q == CODE_MAX));

    // Hold counter: reload on every clipped code, otherwise count down to 0.
    always_comb begin
        hold_d = hold_q;
        if (ovr_hit)           hold_d = HOLD_LOAD;
        else if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    assign ovr      = (hold_q != '0);
    assign o_valid  = o_valid_q;
    assign o_data   = o_data_q;
    assign drop_cnt = drop_cnt_q;

endmodule
